// File: rtl/tpu_driver.sv
// Sequences one TPU job: streams 32 bytes in as LOAD words, issues COMPUTE_CYCLES COMPUTEs, then READs 16 result bytes.
// Instruction is registered one cycle after its cause; in_ready is high only in LOAD; each result byte is held until out_ready.
module tpu_driver #(
    parameter int COMPUTE_CYCLES = 10,
    parameter int READ_LAT       = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [15:0] instruction,
    input  logic [7:0]  result,
    output logic [7:0]  out_data,
    output logic [3:0]  out_index,
    output logic        out_valid,
    input  logic        out_ready
);

    localparam int CW = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;
    localparam int LW = (READ_LAT > 0) ? $clog2(READ_LAT + 1) : 1;

    localparam logic [15:0] INSTR_NOP     = 16'h0000;
    localparam logic [15:0] INSTR_COMPUTE = 16'h8000;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        COMPUTE,
        RD_ISSUE,
        RD_WAIT,
        OUT_HOLD
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [4:0]      ld_cnt;
    logic [CW-1:0]   cmp_cnt;
    logic [LW-1:0]   lat_cnt;
    logic [3:0]      rd_idx;
    logic [15:0]     instr_d;

    logic load_acc;
    logic load_last;
    logic cmp_last;
    logic lat_hit;
    logic out_hs;
    logic idx_last;

    assign in_ready  = (state_q == LOAD);
    assign busy      = (state_q != IDLE);
    assign load_acc  = in_ready && in_valid;
    assign load_last = load_acc && (ld_cnt == 5'd31);
    assign cmp_last  = (cmp_cnt == CW'(COMPUTE_CYCLES - 1));
    assign lat_hit   = (lat_cnt == LW'(READ_LAT));
    assign out_hs    = out_valid && out_ready;
    assign idx_last  = (rd_idx == 4'd15);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        instr_d = INSTR_NOP;
        case (state_q)
            IDLE: begin
                if (start) state_d = LOAD;
            end
            LOAD: begin
                // Byte k lands at mem=k[4], line=k[3:2], elem=k[1:0].
                if (load_acc) instr_d = {2'b01, ld_cnt[4], ld_cnt[3:2], ld_cnt[1:0], 1'b0, in_data};
                if (load_last) state_d = COMPUTE;
            end
            COMPUTE: begin
                instr_d = INSTR_COMPUTE;
                if (cmp_last) state_d = RD_ISSUE;
            end
            RD_ISSUE: begin
                instr_d = {2'b11, 10'd0, rd_idx};
                state_d = RD_WAIT;
            end
            RD_WAIT: begin
                if (lat_hit) state_d = OUT_HOLD;
            end
            OUT_HOLD: begin
                if (out_hs) state_d = idx_last ? IDLE : RD_ISSUE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            instruction <= INSTR_NOP;
            ld_cnt      <= '0;
            cmp_cnt     <= '0;
            lat_cnt     <= '0;
            rd_idx      <= '0;
            out_data    <= '0;
            out_index   <= '0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            instruction <= instr_d;
            done        <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) ld_cnt <= '0;
                end
                LOAD: begin
                    if (load_last) begin
                        cmp_cnt <= '0;
                    end else if (load_acc) begin
                        ld_cnt <= ld_cnt + 5'd1;
                    end
                end
                COMPUTE: begin
                    if (cmp_last) begin
                        rd_idx <= '0;
                    end else begin
                        cmp_cnt <= cmp_cnt + CW'(1);
                    end
                end
                RD_ISSUE: begin
                    lat_cnt <= '0;
                end
                RD_WAIT: begin
                    // lat_cnt counts edges since the READ word went out; result is valid at READ_LAT.
                    if (lat_hit) begin
                        out_data  <= result;
                        out_index <= rd_idx;
                        out_valid <= 1'b1;
                    end else begin
                        lat_cnt <= lat_cnt + LW'(1);
                    end
                end
                OUT_HOLD: begin
                    if (out_hs) begin
                        out_valid <= 1'b0;
                        if (idx_last) begin
                            done <= 1'b1;
                        end else begin
                            rd_idx <= rd_idx + 4'd1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
